mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum bus wait cycles before bus error (1..65535).
REQ-003 SHALL have parameter BIG_ENDIAN, default 1; 1 = byte offset 0 on lane [31:24], 0 = byte offset 0 on lane [7:0].
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset (`RstEnable).
REQ-005 SHALL have ports: valid_i in 1; aluop_i in 8 (`AluOpBus); mem_addr_i in 32; reg2_i in 32; wd_i in 5; wreg_i in 1; wdata_i in 32; flush_i in 1.
REQ-006 SHALL have bus ports: bus_req_o out 1; bus_we_o out 1; bus_addr_o out ADDR_W; bus_sel_o out 4; bus_wdata_o out 32; bus_ack_i in 1; bus_rdata_i in 32.
REQ-007 SHALL have result ports: stallreq_o out 1; valid_o out 1; wd_o out 5; wreg_o out 1; wdata_o out 32; bus_err_o out 1; adel_o out 1; ades_o out 1; llbit_o out 1.

Function
REQ-008 SHALL treat LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC as memory ops; every other aluop_i is pass-through.
REQ-009 SHALL register a pass-through op (wd, wreg, wdata) to the outputs with valid_o=1 exactly 1 cycle after valid_i.
REQ-010 SHALL use FSM IDLE -> REQ -> IDLE: a valid memory op in IDLE is captured, and the state goes to REQ on the next edge.
REQ-011 SHALL hold bus_req_o=1 and keep bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o constant for the whole of REQ until bus_ack_i is sampled high.
REQ-012 SHALL register the result on the ack edge, pulse valid_o for 1 cycle and return to IDLE; minimum memory-op latency valid_i -> valid_o is 2 cycles.
REQ-013 SHALL assert stallreq_o combinationally from a valid memory op in IDLE through the REQ cycle in which ack is seen; stallreq_o=0 otherwise.
REQ-014 SHALL drive byte lanes per BIG_ENDIAN: byte sel one-hot on the offset lane; halfword sel 1100/0011; word sel 1111. Store data is replicated on all lanes.
REQ-015 SHALL sign-extend loaded data for LB/LH and zero-extend it for LBU/LHU.
REQ-016 SHALL drive bus_addr_o = mem_addr_i[ADDR_W-1:0] with the low 2 bits cleared.
REQ-017 SHALL own an internal LL bit: LL completion sets it to 1; any SC completion clears it; flush_i clears it.
REQ-018 SHALL handle SC with LL bit=0 with no bus access: valid_o next cycle, wdata_o=0, wreg_o=wreg_i. SC with LL bit=1 SHALL do a word store and return wdata_o=1. llbit_o reflects the LL bit.
REQ-019 SHALL count REQ cycles with a counter. When the count reaches TIMEOUT without an ack, the unit SHALL drop bus_req_o, pulse valid_o and bus_err_o together with wreg_o=0, and return to IDLE.
REQ-020 SHALL handle flush_i in IDLE by discarding the captured op (no bus access, no valid_o).
REQ-021 SHALL handle flush_i in REQ by holding bus_req_o until ack or timeout, then returning to IDLE with no valid_o; an LL completing under flush SHALL leave the LL bit at 0.
REQ-022 SHALL give flush_i priority over a simultaneous new valid_i, which is ignored.
REQ-023 SHALL ignore valid_i while in REQ (the upstream stage is held by stallreq_o).

Reset
REQ-024 SHALL, on reset, go to IDLE with a zero counter, LL bit=0, and all outputs 0; wd_o=`NOPRegAddr.
REQ-025 SHALL, on reset during REQ, drop bus_req_o at the next edge with no valid_o; the lost transaction is not reported.

Configuration
REQ-026 SHALL implement the macro MEM_LSU_ALIGN_EXC_EN.
- With MEM_LSU_ALIGN_EXC_EN defined: LH/LHU with addr[0]=1, or LW/LL with addr[1:0]!=0, SHALL produce no bus access, valid_o+adel_o next cycle and wreg_o=0. Misaligned SH/SW/SC SHALL do likewise with ades_o.
- Without MEM_LSU_ALIGN_EXC_EN: adel_o=ades_o=0, and misaligned accesses proceed with the offset bits ignored for lane selection (forced aligned).

Structure
REQ-027 SHALL add the aluop codes, the FSM state encodings (IDLE=2'b00, REQ=2'b01) and the bus sel constants to the shared defines.v.
REQ-028 SHALL place lane steering and extension in one combinational sub-module, mem_lsu_lane. The FSM, counter and LL bit SHALL stay in mem_lsu.

Verification
REQ-029 SHALL cover LB at 0x0000_1001, BIG_ENDIAN=1, rdata 0x1180_3344, ack after 3 cycles -> sel=0100, wdata_o=0xFFFF_FF80, stallreq_o high 4 cycles.
REQ-030 SHALL cover SH reg2=0x0000_ABCD at 0x...0002 -> bus_we_o=1, sel=0011, bus_wdata_o=0xABCD_ABCD.
REQ-031 SHALL cover LL 0x100, then SC 0x100 (reg2=7) -> SC stores 7, wdata_o=1, llbit_o goes 1 then 0; a second SC -> no bus_req_o, wdata_o=0.
REQ-032 SHALL cover TIMEOUT=4 with ack never asserted -> bus_req_o high 4 cycles, then bus_err_o=valid_o=1 and wreg_o=0.
REQ-033 SHALL cover flush_i in the second REQ cycle of an LW, with ack 2 cycles later -> req held until ack, no valid_o; a pass-through add next -> valid_o after 1 cycle.
REQ-034 SHALL cover LW at 0x...0006 with MEM_LSU_ALIGN_EXC_EN defined -> adel_o=1, no bus_req_o; without the macro -> access at 0x...0004, sel=1111.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg -- shared definitions for the load/store unit.
//   * ALU operation codes for the memory ops handled by mem_lsu
//   * FSM state encoding (IDLE = 2'b00, REQ = 2'b01)
//   * byte-lane select constants and small op-class decode helpers
package mem_lsu_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_HI   = 4'b1100;
    localparam logic [3:0] SEL_LO   = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01
    } lsu_state_e;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP: is_load = 1'b1;
            default: is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: is_store = 1'b1;
            default: is_store = 1'b0;
        endcase
    endfunction

    // Natural-alignment violation for the access size implied by op.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           is_misaligned = off[0];
            EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP: is_misaligned = (off != 2'b00);
            default:                                    is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane -- combinational byte-lane steering and load extension.
// Ports:
//   aluop_i  captured memory op         off_i   captured address offset [1:0]
//   reg2_i   captured store operand     rdata_i bus read data
//   sel_o    bus byte-lane select       wdata_o store data replicated on all lanes
//   ldata_o  load result, sign/zero extended
// BIG_ENDIAN=1 places byte offset 0 on lane [31:24]. Offset bits finer than the
// access size are ignored, so a misaligned access is steered as if aligned.
module mem_lsu_lane
    import mem_lsu_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [1:0]  byte_lane_s;
    logic        half_hi_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane index from offset, then select/replicate/extend per op
    always_comb begin
        byte_lane_s = (BIG_ENDIAN != 0) ? (2'd3 - off_i) : off_i;
        half_hi_s   = (BIG_ENDIAN != 0) ? ~off_i[1] : off_i[1];
        byte_s      = rdata_i[{byte_lane_s, 3'b000} +: 8];
        half_s      = rdata_i[{half_hi_s, 4'b0000} +: 16];
        sel_o       = SEL_NONE;
        wdata_o     = 32'h0000_0000;
        ldata_o     = 32'h0000_0000;
        case (aluop_i)
            EXE_LB_OP:  begin sel_o = 4'b0001 << byte_lane_s; ldata_o = {{24{byte_s[7]}}, byte_s}; end
            EXE_LBU_OP: begin sel_o = 4'b0001 << byte_lane_s; ldata_o = {24'h00_0000, byte_s}; end
            EXE_LH_OP:  begin sel_o = half_hi_s ? SEL_HI : SEL_LO; ldata_o = {{16{half_s[15]}}, half_s}; end
            EXE_LHU_OP: begin sel_o = half_hi_s ? SEL_HI : SEL_LO; ldata_o = {16'h0000, half_s}; end
            EXE_LW_OP, EXE_LL_OP: begin sel_o = SEL_WORD; ldata_o = rdata_i; end
            EXE_SB_OP:  begin sel_o = 4'b0001 << byte_lane_s; wdata_o = {4{reg2_i[7:0]}}; end
            EXE_SH_OP:  begin sel_o = half_hi_s ? SEL_HI : SEL_LO; wdata_o = {2{reg2_i[15:0]}}; end
            EXE_SW_OP, EXE_SC_OP: begin sel_o = SEL_WORD; wdata_o = reg2_i; end
            default: begin sel_o = SEL_NONE; wdata_o = 32'h0000_0000; ldata_o = 32'h0000_0000; end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu -- load/store unit: single-outstanding bus master with LL/SC support.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i, aluop_i, mem_addr_i, reg2_i, wd_i, wreg_i, wdata_i, flush_i   op from execute
//   bus_req_o/we_o/addr_o/sel_o/wdata_o, bus_ack_i, bus_rdata_i             memory bus
//   stallreq_o, valid_o, wd_o, wreg_o, wdata_o                             result / pipeline control
//   bus_err_o (timeout), adel_o/ades_o (misaligned load/store), llbit_o
// Build option: define MEM_LSU_ALIGN_EXC_EN to trap misaligned accesses as
// adel_o/ades_o; otherwise misaligned accesses run forced-aligned.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              stallreq_o,
    output logic              valid_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              bus_err_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              llbit_o
);

    lsu_state_e        state_r, state_nx_s;
    logic [15:0]       cnt_r, cnt_nx_s;
    logic              llbit_r, llbit_nx_s, flushed_r, flushed_nx_s;
    logic              req_r, we_r, wreg_r;
    logic [7:0]        aluop_r;
    logic [1:0]        off_r;
    logic [31:0]       reg2_r;
    logic [ADDR_W-1:0] addr_r;
    logic [4:0]        wd_r;
    logic              valid_r, valid_nx_s, wreg_out_r, wreg_nx_s;
    logic [4:0]        wd_out_r, wd_nx_s;
    logic [31:0]       wdata_out_r, wdata_nx_s, ldata_s;
    logic              err_r, err_nx_s, adel_r, adel_nx_s, ades_r, ades_nx_s;
    logic              accept_s, capture_s, stall_s, adel_s, ades_s, timeout_s;

    mem_lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .aluop_i (aluop_r),
        .off_i   (off_r),
        .reg2_i  (reg2_r),
        .rdata_i (bus_rdata_i),
        .sel_o   (bus_sel_o),
        .wdata_o (bus_wdata_o),
        .ldata_o (ldata_s)
    );

    assign accept_s  = (state_r == ST_IDLE) && valid_i && !flush_i;
    assign timeout_s = (cnt_r == 16'(TIMEOUT - 1));

    // Alignment trap decode for the incoming op
    always_comb begin
`ifdef MEM_LSU_ALIGN_EXC_EN
        adel_s = is_load(aluop_i) && is_misaligned(aluop_i, mem_addr_i[1:0]);
        ades_s = is_store(aluop_i) && is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
        adel_s = 1'b0;
        ades_s = 1'b0;
`endif
    end

    // Next state, stall request, and next values of the registered results
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        llbit_nx_s   = llbit_r;
        flushed_nx_s = flushed_r;
        capture_s    = 1'b0;
        stall_s      = 1'b0;
        valid_nx_s   = 1'b0;
        wd_nx_s      = NOP_REG_ADDR;
        wreg_nx_s    = 1'b0;
        wdata_nx_s   = 32'h0000_0000;
        err_nx_s     = 1'b0;
        adel_nx_s    = 1'b0;
        ades_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s     = 16'd0;
                flushed_nx_s = 1'b0;
                if (accept_s && (is_load(aluop_i) || is_store(aluop_i))) begin
                    stall_s = 1'b1;
                    if (adel_s || ades_s) begin
                        valid_nx_s = 1'b1;
                        wd_nx_s    = wd_i;
                        adel_nx_s  = adel_s;
                        ades_nx_s  = ades_s;
                    end else if ((aluop_i == EXE_SC_OP) && !llbit_r) begin
                        // Failed SC: report 0 without touching the bus
                        valid_nx_s = 1'b1;
                        wd_nx_s    = wd_i;
                        wreg_nx_s  = wreg_i;
                    end else begin
                        capture_s  = 1'b1;
                        state_nx_s = ST_REQ;
                    end
                end else if (accept_s) begin
                    valid_nx_s = 1'b1;
                    wd_nx_s    = wd_i;
                    wreg_nx_s  = wreg_i;
                    wdata_nx_s = wdata_i;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (bus_ack_i || timeout_s) begin
                    state_nx_s   = ST_IDLE;
                    cnt_nx_s     = 16'd0;
                    flushed_nx_s = 1'b0;
                    if (aluop_r == EXE_SC_OP) begin
                        llbit_nx_s = 1'b0;
                    end else if (bus_ack_i && (aluop_r == EXE_LL_OP) && !flushed_r && !flush_i) begin
                        llbit_nx_s = 1'b1;
                    end else begin
                        llbit_nx_s = llbit_r;
                    end
                    if (flushed_r || flush_i) begin
                        valid_nx_s = 1'b0;
                    end else if (bus_ack_i) begin
                        valid_nx_s = 1'b1;
                        wd_nx_s    = wd_r;
                        wreg_nx_s  = wreg_r;
                        if (aluop_r == EXE_SC_OP) begin
                            wdata_nx_s = 32'd1;
                        end else if (is_store(aluop_r)) begin
                            wdata_nx_s = 32'd0;
                        end else begin
                            wdata_nx_s = ldata_s;
                        end
                    end else begin
                        valid_nx_s = 1'b1;
                        err_nx_s   = 1'b1;
                        wd_nx_s    = wd_r;
                    end
                end else begin
                    cnt_nx_s     = cnt_r + 16'd1;
                    flushed_nx_s = flushed_r | flush_i;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, transaction capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            llbit_r     <= 1'b0;
            flushed_r   <= 1'b0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            aluop_r     <= 8'h00;
            off_r       <= 2'b00;
            reg2_r      <= 32'h0000_0000;
            addr_r      <= '0;
            wd_r        <= NOP_REG_ADDR;
            wreg_r      <= 1'b0;
            valid_r     <= 1'b0;
            wd_out_r    <= NOP_REG_ADDR;
            wreg_out_r  <= 1'b0;
            wdata_out_r <= 32'h0000_0000;
            err_r       <= 1'b0;
            adel_r      <= 1'b0;
            ades_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            llbit_r     <= flush_i ? 1'b0 : llbit_nx_s;
            flushed_r   <= flushed_nx_s;
            req_r       <= (state_nx_s == ST_REQ);
            valid_r     <= valid_nx_s;
            wd_out_r    <= wd_nx_s;
            wreg_out_r  <= wreg_nx_s;
            wdata_out_r <= wdata_nx_s;
            err_r       <= err_nx_s;
            adel_r      <= adel_nx_s;
            ades_r      <= ades_nx_s;
            if (capture_s) begin
                we_r    <= is_store(aluop_i);
                aluop_r <= aluop_i;
                off_r   <= mem_addr_i[1:0];
                reg2_r  <= reg2_i;
                addr_r  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                wd_r    <= wd_i;
                wreg_r  <= wreg_i;
            end
        end
    end

    assign bus_req_o  = req_r;
    assign bus_we_o   = we_r;
    assign bus_addr_o = addr_r;
    assign stallreq_o = stall_s;
    assign valid_o    = valid_r;
    assign wd_o       = wd_out_r;
    assign wreg_o     = wreg_out_r;
    assign wdata_o    = wdata_out_r;
    assign bus_err_o  = err_r;
    assign adel_o     = adel_r;
    assign ades_o     = ades_r;
    assign llbit_o    = llbit_r;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu -- directed, table-driven bench for mem_lsu (BIG_ENDIAN=1, TIMEOUT=4).
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    logic        clk, rst, valid_i, wreg_i, flush_i, bus_ack_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
    logic [4:0]  wd_i;
    logic        bus_req_o, bus_we_o, stallreq_o, valid_o, wreg_o, bus_err_o, adel_o, ades_o, llbit_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  wd_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_lsu #(.ADDR_W(32), .TIMEOUT(4), .BIG_ENDIAN(1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stallreq_o(stallreq_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .bus_err_o(bus_err_o), .adel_o(adel_o), .ades_o(ades_o), .llbit_o(llbit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // din is bus read data for loads and wdata_i for pass-through ops
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] din;
        int          ack_at;
        logic        wreg_in;
        int          n_req;
        int          n_stall;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] res;
        logic        res_wreg;
        logic        err;
        logic        adel;
        logic        ades;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                input logic [31:0] din, input int ack_at, input logic wreg_in,
                                input int n_req, input int n_stall, input logic [3:0] sel, input logic we,
                                input logic [31:0] baddr, input logic [31:0] bwdata, input logic [31:0] res,
                                input logic res_wreg, input logic err, input logic adel, input logic ades);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.din = din; v.ack_at = ack_at; v.wreg_in = wreg_in;
        v.n_req = n_req; v.n_stall = n_stall; v.sel = sel; v.we = we; v.baddr = baddr; v.bwdata = bwdata;
        v.res = res; v.res_wreg = res_wreg; v.err = err; v.adel = adel; v.ades = ades;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one op for a single cycle, answer the bus, then check the result
    task automatic apply(input vec_t v, input string tag);
        int stall_n;
        int req_n;
        stall_n = 0;
        req_n   = 0;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2;
        wdata_i = v.din; wd_i = 5'd9; wreg_i = v.wreg_in;
        #1;
        if (stallreq_o) stall_n++;
        @(negedge clk);
        valid_i = 1'b0;
        while (bus_req_o && req_n < 20) begin
            req_n++;
            if (req_n == 1) begin
                chk({tag, ".addr"}, bus_addr_o, v.baddr);
                chk({tag, ".sel"}, {28'd0, bus_sel_o}, {28'd0, v.sel});
                chk({tag, ".we"}, {31'd0, bus_we_o}, {31'd0, v.we});
                chk({tag, ".bwdata"}, bus_wdata_o, v.bwdata);
            end
            if (req_n == v.ack_at) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = v.din;
            end
            #1;
            if (stallreq_o) stall_n++;
            @(negedge clk);
            bus_ack_i = 1'b0;
        end
        chk({tag, ".req_cycles"}, 32'(req_n), 32'(v.n_req));
        chk({tag, ".stall_cycles"}, 32'(stall_n), 32'(v.n_stall));
        chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, ".wreg"}, {31'd0, wreg_o}, {31'd0, v.res_wreg});
        chk({tag, ".err"}, {31'd0, bus_err_o}, {31'd0, v.err});
        chk({tag, ".adel"}, {31'd0, adel_o}, {31'd0, v.adel});
        chk({tag, ".ades"}, {31'd0, ades_o}, {31'd0, v.ades});
        if (!v.err && !v.adel && !v.ades) chk({tag, ".wdata"}, wdata_o, v.res);
        if (v.res_wreg) chk({tag, ".wd"}, {27'd0, wd_o}, 32'd9);
    endtask

    vec_t vecs[12];
    int   vld_seen;

    initial begin
        rst = 1'b1; valid_i = 1'b0; aluop_i = 8'h00; mem_addr_i = 32'h0; reg2_i = 32'h0;
        wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

        //            op          addr          reg2          din           ack wr req stl sel      we   baddr         bwdata        res           rw   err  adel ades
        vecs[0]  = mk(ADD_OP,     32'h0000_0000, 32'h0,        32'h1234_5678, 0, 1'b1, 0, 0, 4'b0000, 1'b0, 32'h0,        32'h0,        32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(EXE_LB_OP,  32'h0000_1001, 32'h0,        32'h1180_3344, 3, 1'b1, 3, 4, 4'b0100, 1'b0, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(EXE_LBU_OP, 32'h0000_1001, 32'h0,        32'h1180_3344, 1, 1'b1, 1, 2, 4'b0100, 1'b0, 32'h0000_1000, 32'h0,        32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(EXE_LH_OP,  32'h0000_2000, 32'h0,        32'h8001_7F00, 1, 1'b1, 1, 2, 4'b1100, 1'b0, 32'h0000_2000, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(EXE_LHU_OP, 32'h0000_2002, 32'h0,        32'h8001_F00F, 1, 1'b1, 1, 2, 4'b0011, 1'b0, 32'h0000_2000, 32'h0,        32'h0000_F00F, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(EXE_LW_OP,  32'h0000_3008, 32'h0,        32'hDEAD_BEEF, 2, 1'b1, 2, 3, 4'b1111, 1'b0, 32'h0000_3008, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(EXE_SB_OP,  32'h0000_4003, 32'h0000_00A5, 32'h0,        1, 1'b0, 1, 2, 4'b0001, 1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(EXE_SH_OP,  32'h0000_0402, 32'h0000_ABCD, 32'h0,        1, 1'b0, 1, 2, 4'b0011, 1'b1, 32'h0000_0400, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(EXE_SW_OP,  32'h0000_5004, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 1, 2, 4'b1111, 1'b1, 32'h0000_5004, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MEM_LSU_ALIGN_EXC_EN
        vecs[9]  = mk(EXE_LW_OP,  32'h0000_0006, 32'h0,        32'h0102_0304, 1, 1'b1, 0, 1, 4'b0000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
`else
        vecs[9]  = mk(EXE_LW_OP,  32'h0000_0006, 32'h0,        32'h0102_0304, 1, 1'b1, 1, 2, 4'b1111, 1'b0, 32'h0000_0004, 32'h0,        32'h0102_0304, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        vecs[10] = mk(EXE_LW_OP,  32'h0000_6000, 32'h0,        32'h0,        0, 1'b1, 4, 5, 4'b1111, 1'b0, 32'h0000_6000, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(EXE_SC_OP,  32'h0000_0100, 32'h0000_0007, 32'h0,        1, 1'b1, 0, 1, 4'b0000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.wd", {27'd0, wd_o}, 32'd0);
        chk("rst.wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst.wdata", wdata_o, 32'd0);
        chk("rst.llbit", {31'd0, llbit_o}, 32'd0);
        chk("rst.sel", {28'd0, bus_sel_o}, 32'd0);
        chk("rst.stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // LL then successful SC, then a failing SC
        apply(mk(EXE_LL_OP, 32'h100, 32'h0, 32'h5555_AAAA, 1, 1'b1, 1, 2, 4'b1111, 1'b0, 32'h100, 32'h0, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 1'b0), "ll");
        chk("ll.llbit", {31'd0, llbit_o}, 32'd1);
        apply(mk(EXE_SC_OP, 32'h100, 32'h7, 32'h0, 1, 1'b1, 1, 2, 4'b1111, 1'b1, 32'h100, 32'h7, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0), "sc1");
        chk("sc1.llbit", {31'd0, llbit_o}, 32'd0);
        apply(mk(EXE_SC_OP, 32'h100, 32'h7, 32'h0, 1, 1'b1, 0, 1, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0), "sc2");

        // Flush in the second REQ cycle of an LW; ack arrives later
        vld_seen = 0;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h7000; wreg_i = 1'b1; wd_i = 5'd9;
        @(negedge clk);
        valid_i = 1'b0;
        chk("fl.req_c1", {31'd0, bus_req_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b1;
        chk("fl.req_c2", {31'd0, bus_req_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        vld_seen += int'(valid_o);
        chk("fl.req_c3", {31'd0, bus_req_o}, 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        @(negedge clk);
        bus_ack_i = 1'b0;
        vld_seen += int'(valid_o);
        chk("fl.req_done", {31'd0, bus_req_o}, 32'd0);
        chk("fl.no_valid", 32'(vld_seen), 32'd0);
        apply(mk(ADD_OP, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 1'b1, 0, 0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 1'b0), "fl_add");

        // Flush in IDLE wins over a simultaneous new op
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h7100; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        chk("fli.req", {31'd0, bus_req_o}, 32'd0);
        chk("fli.valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        chk("fli.req2", {31'd0, bus_req_o}, 32'd0);

        // Reset while waiting in REQ
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h7200;
        @(negedge clk);
        valid_i = 1'b0;
        chk("rq.req", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rq.req_drop", {31'd0, bus_req_o}, 32'd0);
        chk("rq.valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        chk("rq.valid2", {31'd0, valid_o}, 32'd0);
        chk("rq.req2", {31'd0, bus_req_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
